// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared loader FSM states and the default halt word.
package prog_mem_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
    localparam logic [63:0] HALT_WORD_DEFAULT = '1;
endpackage

// File: rtl/inst_ram_1r1w.sv
// inst_ram_1r1w: instruction storage with one synchronous write port and one registered read port.
module inst_ram_1r1w #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_we,
    input  logic [A-1:0] i_waddr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_re,
    input  logic [A-1:0] i_raddr,
    output logic [W-1:0] o_rdata
);
    logic [W-1:0] r_mem [2**A];
    logic [W-1:0] r_rdata;

    // Only the read register is reset; the array keeps its contents.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_rst) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/inst_ram_loader.sv
// inst_ram_loader: streams a program into instruction RAM, then serves
// registered fetches, returning HALT_WORD past the loaded length.
module inst_ram_loader
    import prog_mem_pkg::*;
#(
    parameter int             A         = 10,
    parameter int             W         = 9,
    parameter logic [W-1:0]   HALT_WORD = W'(HALT_WORD_DEFAULT)
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         LoadStart,
    input  logic         LoadValid,
    input  logic [W-1:0] LoadData,
    input  logic         LoadLast,
    output logic         LoadReady,
    input  logic         InstReq,
    input  logic [A-1:0] InstAddress,
    output logic [W-1:0] InstOut,
    output logic         InstValid,
    output logic [A:0]   ProgLen,
    output logic         Loaded,
    output logic         Overflow
);
    state_t       r_state, w_next;
    logic [A-1:0] r_wr_ptr;
    logic [A:0]   r_prog_len;
    logic         r_overflow, r_valid, r_halt;
    logic         w_start, w_xfer, w_done, w_fetch, w_halt;
    logic [W-1:0] w_rdata;

    always_comb begin
        w_start = LoadStart && r_state != S_LOAD;
        w_xfer  = LoadValid && r_state == S_LOAD;
        w_done  = w_xfer && (LoadLast || &r_wr_ptr);
        w_fetch = InstReq && r_state == S_RUN && !LoadStart;
        w_halt  = {1'b0, InstAddress} >= r_prog_len;
        w_next  = w_start ? S_LOAD : w_done ? S_RUN : r_state;
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // The pointer saturates at the top word so an overflowing load never wraps.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr   <= '0;
            r_prog_len <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            r_valid <= w_fetch;
            if (w_fetch) r_halt <= w_halt;
            if (w_start) begin
                r_wr_ptr   <= '0;
                r_overflow <= 1'b0;
            end else if (w_xfer) begin
                if (!(&r_wr_ptr)) r_wr_ptr <= r_wr_ptr + A'(1);
                if (w_done) begin
                    r_prog_len <= {1'b0, r_wr_ptr} + (A+1)'(1);
                    r_overflow <= !LoadLast;
                end
            end
        end
    end

    inst_ram_1r1w #(.A(A), .W(W)) u_ram (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_we    (w_xfer && !Reset),
        .i_waddr (r_wr_ptr),
        .i_wdata (LoadData),
        .i_re    (w_fetch && !w_halt),
        .i_raddr (InstAddress),
        .o_rdata (w_rdata)
    );

    assign LoadReady = r_state == S_LOAD;
    assign Loaded    = r_state == S_RUN;
    assign Overflow  = r_overflow;
    assign ProgLen   = r_prog_len;
    assign InstValid = r_valid;
    assign InstOut   = r_halt ? HALT_WORD : w_rdata;
endmodule

// File: tb/tb_inst_ram_loader.sv
// tb_inst_ram_loader: directed checks of load, fetch, halt, overflow, restart and reset behaviour.
module tb_inst_ram_loader;
    logic       Clk = 1'b0;
    logic       Reset, LoadStart, LoadValid, LoadLast, InstReq;
    logic [8:0] LoadData;
    logic [3:0] InstAddress;
    logic       LoadReady, InstValid, Loaded, Overflow;
    logic [8:0] InstOut;
    logic [4:0] ProgLen;
    int total = 0;
    int bad = 0;

    inst_ram_loader #(.A(4), .W(9)) dut (
        .Clk(Clk), .Reset(Reset), .LoadStart(LoadStart), .LoadValid(LoadValid),
        .LoadData(LoadData), .LoadLast(LoadLast), .LoadReady(LoadReady),
        .InstReq(InstReq), .InstAddress(InstAddress), .InstOut(InstOut),
        .InstValid(InstValid), .ProgLen(ProgLen), .Loaded(Loaded), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task tick;
        @(posedge Clk);
        #1;
    endtask

    task load_word(input logic [8:0] d, input logic last);
        LoadValid = 1'b1;
        LoadData = d;
        LoadLast = last;
        tick;
        LoadValid = 1'b0;
        LoadLast = 1'b0;
    endtask

    task fetch(input logic [3:0] a);
        InstReq = 1'b1;
        InstAddress = a;
        tick;
        InstReq = 1'b0;
    endtask

    task test_reset;
        Reset = 1'b1; LoadStart = 1'b1; LoadValid = 1'b0; LoadLast = 1'b0; LoadData = '0;
        InstReq = 1'b1; InstAddress = '0;
        tick; tick;
        total++; if (LoadReady !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", LoadReady); end
        total++; if (InstValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", InstValid); end
        total++; if (InstOut !== 9'h000) begin bad++; $display("FAIL reset_instout got=%h exp=000", InstOut); end
        total++; if (ProgLen !== 5'd0) begin bad++; $display("FAIL reset_proglen got=%0d exp=0", ProgLen); end
        total++; if (Loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded got=%b exp=0", Loaded); end
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", Overflow); end
        Reset = 1'b0; LoadStart = 1'b0; InstReq = 1'b0;
        tick;
        fetch(4'd0);
        total++; if (InstValid !== 1'b0) begin bad++; $display("FAIL idle_fetch_ignored got=%b exp=0", InstValid); end
    endtask

    task test_load;
        LoadStart = 1'b1; tick; LoadStart = 1'b0;
        total++; if (LoadReady !== 1'b1) begin bad++; $display("FAIL load_ready got=%b exp=1", LoadReady); end
        load_word(9'h0C8, 1'b0);
        load_word(9'h0AA, 1'b0);
        load_word(9'h155, 1'b1);
        total++; if (ProgLen !== 5'd3) begin bad++; $display("FAIL load_proglen got=%0d exp=3", ProgLen); end
        total++; if (Loaded !== 1'b1) begin bad++; $display("FAIL load_loaded got=%b exp=1", Loaded); end
        total++; if (LoadReady !== 1'b0) begin bad++; $display("FAIL load_ready_after got=%b exp=0", LoadReady); end
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL load_overflow got=%b exp=0", Overflow); end
    endtask

    task test_fetch;
        fetch(4'd1);
        total++; if (InstValid !== 1'b1) begin bad++; $display("FAIL fetch1_valid got=%b exp=1", InstValid); end
        total++; if (InstOut !== 9'h0AA) begin bad++; $display("FAIL fetch1_data got=%h exp=0aa", InstOut); end
        tick;
        total++; if (InstValid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", InstValid); end
        total++; if (InstOut !== 9'h0AA) begin bad++; $display("FAIL idle_hold got=%h exp=0aa", InstOut); end
        fetch(4'd7);
        total++; if (InstOut !== 9'h1FF || InstValid !== 1'b1) begin bad++; $display("FAIL fetch7_halt got=%h/%b exp=1ff/1", InstOut, InstValid); end
        fetch(4'd3);
        total++; if (InstOut !== 9'h1FF) begin bad++; $display("FAIL fetch3_boundary got=%h exp=1ff", InstOut); end
    endtask

    task test_back_to_back;
        logic [3:0] addrs [4];
        logic [8:0] exps [4];
        addrs = '{4'd0, 4'd1, 4'd2, 4'd5};
        exps = '{9'h0C8, 9'h0AA, 9'h155, 9'h1FF};
        InstReq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            InstAddress = addrs[i];
            tick;
            total++; if (InstValid !== 1'b1 || InstOut !== exps[i]) begin bad++; $display("FAIL b2b_%0d got=%h/%b exp=%h/1", i, InstOut, InstValid, exps[i]); end
        end
        InstReq = 1'b0;
    endtask

    task test_stall;
        LoadStart = 1'b1; tick; LoadStart = 1'b0;
        load_word(9'h011, 1'b0);
        load_word(9'h022, 1'b0);
        LoadData = 9'h0EE; tick; tick;
        total++; if (LoadReady !== 1'b1 || Loaded !== 1'b0) begin bad++; $display("FAIL stall_state got=%b/%b exp=1/0", LoadReady, Loaded); end
        total++; if (ProgLen !== 5'd3) begin bad++; $display("FAIL stall_proglen_held got=%0d exp=3", ProgLen); end
        load_word(9'h033, 1'b0);
        load_word(9'h044, 1'b1);
        total++; if (ProgLen !== 5'd4) begin bad++; $display("FAIL stall_proglen got=%0d exp=4", ProgLen); end
        fetch(4'd2);
        total++; if (InstOut !== 9'h033) begin bad++; $display("FAIL stall_fetch2 got=%h exp=033", InstOut); end
        fetch(4'd3);
        total++; if (InstOut !== 9'h044) begin bad++; $display("FAIL stall_fetch3 got=%h exp=044", InstOut); end
        fetch(4'd4);
        total++; if (InstOut !== 9'h1FF) begin bad++; $display("FAIL stall_fetch4 got=%h exp=1ff", InstOut); end
        fetch(4'd1);
        total++; if (InstOut !== 9'h022) begin bad++; $display("FAIL stall_fetch1 got=%h exp=022", InstOut); end
    endtask

    task test_overflow;
        LoadStart = 1'b1; tick; LoadStart = 1'b0;
        for (int i = 0; i < 16; i++) load_word(9'(i * 3 + 1), 1'b0);
        total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", Overflow); end
        total++; if (ProgLen !== 5'd16) begin bad++; $display("FAIL ovf_proglen got=%0d exp=16", ProgLen); end
        total++; if (Loaded !== 1'b1 || LoadReady !== 1'b0) begin bad++; $display("FAIL ovf_run got=%b/%b exp=1/0", Loaded, LoadReady); end
        load_word(9'h0F0, 1'b1);
        total++; if (ProgLen !== 5'd16 || Overflow !== 1'b1) begin bad++; $display("FAIL ovf_extra got=%0d/%b exp=16/1", ProgLen, Overflow); end
        fetch(4'd0);
        total++; if (InstOut !== 9'h001) begin bad++; $display("FAIL ovf_fetch0 got=%h exp=001", InstOut); end
        fetch(4'd15);
        total++; if (InstOut !== 9'h02E) begin bad++; $display("FAIL ovf_fetch15 got=%h exp=02e", InstOut); end
    endtask

    task test_restart;
        LoadStart = 1'b1; InstReq = 1'b1; InstAddress = 4'd2;
        tick;
        LoadStart = 1'b0; InstReq = 1'b0;
        total++; if (InstValid !== 1'b0) begin bad++; $display("FAIL restart_valid got=%b exp=0", InstValid); end
        total++; if (Loaded !== 1'b0 || LoadReady !== 1'b1) begin bad++; $display("FAIL restart_state got=%b/%b exp=0/1", Loaded, LoadReady); end
        total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL restart_overflow got=%b exp=0", Overflow); end
        total++; if (ProgLen !== 5'd16) begin bad++; $display("FAIL restart_proglen got=%0d exp=16", ProgLen); end
        LoadStart = 1'b1; tick; LoadStart = 1'b0;
        total++; if (LoadReady !== 1'b1) begin bad++; $display("FAIL restart_ignored got=%b exp=1", LoadReady); end
    endtask

    task test_reset_midload;
        load_word(9'h101, 1'b0);
        load_word(9'h102, 1'b0);
        Reset = 1'b1; LoadValid = 1'b1; LoadLast = 1'b1; LoadData = 9'h103;
        tick;
        Reset = 1'b0; LoadValid = 1'b0; LoadLast = 1'b0;
        total++; if (Loaded !== 1'b0 || LoadReady !== 1'b0) begin bad++; $display("FAIL midrst_state got=%b/%b exp=0/0", Loaded, LoadReady); end
        total++; if (ProgLen !== 5'd0) begin bad++; $display("FAIL midrst_proglen got=%0d exp=0", ProgLen); end
        fetch(4'd0);
        total++; if (InstValid !== 1'b0) begin bad++; $display("FAIL midrst_fetch got=%b exp=0", InstValid); end
        load_word(9'h0AB, 1'b1);
        total++; if (Loaded !== 1'b0 || ProgLen !== 5'd0) begin bad++; $display("FAIL idle_loadvalid got=%b/%0d exp=0/0", Loaded, ProgLen); end
    endtask

    initial begin
        test_reset;
        test_load;
        test_fetch;
        test_back_to_back;
        test_stall;
        test_overflow;
        test_restart;
        test_reset_midload;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_ram_loader.md
INST_RAM_LOADER -- requirements
Module: inst_ram_loader

Interface
REQ-001 Parameter A, default 10: number of instruction address bits; depth is 2**A words.
REQ-002 Parameter W, default 9: instruction word width in bits.
REQ-003 Parameter HALT_WORD, default all ones (W bits): word returned for fetches beyond the loaded program.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 LoadStart  input  1  one-cycle pulse; begins a program load at address 0.
REQ-007 LoadValid  input  1  LoadData/LoadLast are valid this cycle.
REQ-008 LoadData  input  W  instruction word to write.
REQ-009 LoadLast  input  1  marks the final word of the program.
REQ-010 LoadReady  output  1  block accepts a load word this cycle.
REQ-011 InstReq  input  1  fetch request for InstAddress.
REQ-012 InstAddress  input  A  fetch address.
REQ-013 InstOut  output  W  fetched instruction, registered.
REQ-014 InstValid  output  1  InstOut is valid this cycle.
REQ-015 ProgLen  output  A+1  number of words in the last completed load.
REQ-016 Loaded  output  1  a complete program is resident (state RUN).
REQ-017 Overflow  output  1  sticky; last load filled memory without LoadLast.

Function
REQ-018 The FSM shall have three states: IDLE, LOAD, RUN.
REQ-019 IDLE: LoadStart -> LOAD with write pointer cleared to 0; fetches are ignored.
REQ-020 LOAD: LoadReady=1; a word transfers only when LoadValid && LoadReady, written to mem[wr_ptr] at that edge; wr_ptr increments by 1.
REQ-021 A transfer with LoadLast=1 shall move to RUN and set ProgLen = wr_ptr+1 on the same edge.
REQ-022 A transfer without LoadLast at wr_ptr = 2**A-1 shall write the word, set Overflow=1, ProgLen=2**A, and move to RUN; wr_ptr shall not wrap.
REQ-023 LoadStart during LOAD shall be ignored; LoadValid without LoadStart in IDLE/RUN shall be ignored, with no write.
REQ-024 RUN: InstReq sampled at edge N gives InstOut and InstValid=1 at edge N+1 (1-cycle latency); no request gives InstValid=0, with InstOut holding its previous value.
REQ-025 A fetch with InstAddress >= ProgLen shall return HALT_WORD with InstValid=1.
REQ-026 LoadStart in RUN shall enter LOAD, clear wr_ptr, Overflow and Loaded; a simultaneous InstReq shall be dropped (InstValid=0 next cycle).
REQ-027 Back-to-back InstReq shall produce one valid word per cycle at full throughput.
REQ-028 ProgLen shall hold its previous value until the next load completes.

Reset
REQ-029 Reset shall force state IDLE, wr_ptr=0, LoadReady=0, InstValid=0, InstOut=0, ProgLen=0, Loaded=0, Overflow=0.
REQ-030 Reset mid-load shall abandon the load. Words already written may remain in the array, but Loaded shall stay 0.
REQ-031 Memory array contents shall not be cleared by reset.
REQ-032 Reset shall take priority over all other inputs in the same cycle.

Structure
REQ-033 The FSM state enum shall live in a shared package, prog_mem_pkg, together with the HALT_WORD default constant.
REQ-034 The storage array shall be a sub-module, inst_ram_1r1w: one synchronous write port and one registered read port, parametrised by A and W.

Verification
REQ-035 A=4, W=9: Reset; LoadStart; stream 3 words 0x0C8,0x0AA,0x155 (last has LoadLast) -> ProgLen=3, Loaded=1, LoadReady=0.
REQ-036 After REQ-035 load, InstReq addr 1 at edge N -> InstOut=0x0AA, InstValid=1 at edge N+1; addr 7 -> InstOut=0x1FF.
REQ-037 A=4: stream 16 words with no LoadLast -> Overflow=1, ProgLen=16, state RUN; 17th LoadValid word is not written.
REQ-038 LoadValid held low for 2 cycles mid-stream -> no writes, wr_ptr unchanged; stream resumes correctly.
REQ-039 RUN: assert LoadStart and InstReq together -> InstValid=0 next cycle, Loaded=0, LoadReady=1.
REQ-040 Reset asserted after 2 of 3 load words -> IDLE, Loaded=0, ProgLen=0; fetches ignored.
